// File: rtl/api_rx_parser_pkg.sv
// Shared constants and state type for the RX report-block parser.
// The optional per-miner statistics bank is enabled with API_RX_STAT_EN.
package api_rx_parser_pkg;

  localparam int unsigned API_RX_BLK_LEN       = 11;
  localparam logic [31:0] API_RX_MARKER        = 32'hbeafbeaf;
  localparam logic [7:0]  API_RX_TAG           = 8'h12;
  localparam int unsigned API_MINER_NUM        = 10;
  localparam int unsigned API_NONCE_FIFO_DEPTH = 512;
  localparam int unsigned STAT_W               = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CHECK,
    ST_WAIT_SPACE,
    ST_EMIT
  } rx_state_e;

endpackage

// File: rtl/api_rx_stat.sv
// Per-miner saturating nonce counters with a registered select mux.
module api_rx_stat
  import api_rx_parser_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_rst,
  input  logic              inc,
  input  logic [3:0]        miner_id,
  input  logic [3:0]        sel,
  output logic [STAT_W-1:0] dout
);

  logic [STAT_W-1:0] cnt [API_MINER_NUM];
  logic [STAT_W-1:0] dout_c;

  // Selections beyond the miner count read back as zero
  always_comb begin
    dout_c = '0;
    for (int unsigned i = 0; i < API_MINER_NUM; i++) begin
      if (sel == 4'(i)) dout_c = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || reg_rst) begin
      for (int unsigned i = 0; i < API_MINER_NUM; i++) cnt[i] <= '0;
      dout <= '0;
    end else begin
      for (int unsigned i = 0; i < API_MINER_NUM; i++) begin
        if (inc && (miner_id == 4'(i)) && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
      dout <= dout_c;
    end
  end

endmodule

// File: rtl/api_rx_parser.sv
// Pops 11-word nonce report blocks, validates marker/tag, forwards good blocks.
// Define API_RX_STAT_EN to build the per-miner statistics bank.
module api_rx_parser
  import api_rx_parser_pkg::*;
#(
  parameter int unsigned BLK_LEN          = API_RX_BLK_LEN,
  parameter int unsigned NONCE_FIFO_DEPTH = API_NONCE_FIFO_DEPTH,
  parameter logic [31:0] MARKER           = API_RX_MARKER,
  parameter logic [7:0]  TAG              = API_RX_TAG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_rst,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_rd_en,
  input  logic [31:0] rx_fifo_dout,
  output logic        nonce_fifo_wr_en,
  output logic [31:0] nonce_fifo_din,
  input  logic [9:0]  nonce_fifo_data_count,
  output logic [31:0] reg_nonce_cnt,
  output logic [15:0] reg_drop_cnt,
  output logic [15:0] reg_sync_err,
  input  logic [3:0]  reg_stat_sel,
  output logic [15:0] reg_stat_dout,
  output logic        busy
);

  localparam int unsigned    IDX_W = $clog2(BLK_LEN + 1);
  localparam logic [IDX_W-1:0] BLK  = IDX_W'(BLK_LEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BLK_LEN - 1);

  rx_state_e        state, state_nxt;
  logic [31:0]      blk_buf [BLK_LEN];
  logic [IDX_W-1:0] issue_cnt, cap_cnt, emit_idx;
  logic [IDX_W-1:0] issued_c;
  logic             rd_d;
  logic             rd_en_nxt, wr_en_nxt;
  logic [31:0]      din_nxt;
  logic             soft_rst_c, tag_ok_c, mark_ok_c, space_ok_c, emit_done_c;

  assign soft_rst_c = rst || reg_rst;
  assign issued_c   = issue_cnt + IDX_W'(rx_fifo_rd_en);
  assign tag_ok_c   = blk_buf[BLK_LEN-1][15:8] == TAG;
  assign mark_ok_c  = blk_buf[BLK_LEN-2] == MARKER;
  assign space_ok_c = (32'(nonce_fifo_data_count) + 32'(BLK_LEN)) <= 32'(NONCE_FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (soft_rst_c) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next state plus next values of the registered FIFO strobes
  always_comb begin
    state_nxt   = state;
    rd_en_nxt   = 1'b0;
    wr_en_nxt   = 1'b0;
    din_nxt     = nonce_fifo_din;
    emit_done_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_fifo_empty) begin
          state_nxt = ST_READ;
          rd_en_nxt = 1'b1;
        end
      end
      ST_READ: begin
        rd_en_nxt = !rx_fifo_empty && (issued_c < BLK);
        if (rd_d && (cap_cnt == LAST)) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        state_nxt = (tag_ok_c && mark_ok_c) ? ST_WAIT_SPACE : ST_IDLE;
      end
      ST_WAIT_SPACE: begin
        if (space_ok_c) begin
          state_nxt = ST_EMIT;
          wr_en_nxt = 1'b1;
          din_nxt   = blk_buf[0];
        end
      end
      ST_EMIT: begin
        if (emit_idx == BLK) begin
          state_nxt   = ST_IDLE;
          emit_done_c = 1'b1;
        end else begin
          wr_en_nxt = 1'b1;
          din_nxt   = blk_buf[emit_idx];
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst_c) begin
      rx_fifo_rd_en    <= 1'b0;
      rd_d             <= 1'b0;
      nonce_fifo_wr_en <= 1'b0;
      nonce_fifo_din   <= '0;
      busy             <= 1'b0;
      issue_cnt        <= '0;
      cap_cnt          <= '0;
      emit_idx         <= '0;
      reg_nonce_cnt    <= '0;
      reg_drop_cnt     <= '0;
      reg_sync_err     <= '0;
    end else begin
      rx_fifo_rd_en    <= rd_en_nxt;
      rd_d             <= rx_fifo_rd_en;
      nonce_fifo_wr_en <= wr_en_nxt;
      nonce_fifo_din   <= din_nxt;
      busy             <= state_nxt != ST_IDLE;
      if (state == ST_CHECK) begin
        issue_cnt <= '0;
        cap_cnt   <= '0;
      end else begin
        if (rx_fifo_rd_en) issue_cnt <= issue_cnt + 1'b1;
        if (rd_d)          cap_cnt   <= cap_cnt + 1'b1;
      end
      if (wr_en_nxt) emit_idx <= (state == ST_EMIT) ? emit_idx + 1'b1 : IDX_W'(1);
      if (state == ST_CHECK && !tag_ok_c && (reg_sync_err != '1))
        reg_sync_err <= reg_sync_err + 1'b1;
      if (state == ST_CHECK && tag_ok_c && !mark_ok_c && (reg_drop_cnt != '1))
        reg_drop_cnt <= reg_drop_cnt + 1'b1;
      if (emit_done_c && (reg_nonce_cnt != '1))
        reg_nonce_cnt <= reg_nonce_cnt + 1'b1;
    end
  end

  // Block buffer is pure datapath; a reset simply abandons its contents
  always_ff @(posedge clk) begin
    if (rd_d && (state == ST_READ)) blk_buf[cap_cnt] <= rx_fifo_dout;
  end

`ifdef API_RX_STAT_EN
  api_rx_stat u_stat (
    .clk      (clk),
    .rst      (rst),
    .reg_rst  (reg_rst),
    .inc      (emit_done_c),
    .miner_id (blk_buf[BLK_LEN-1][3:0]),
    .sel      (reg_stat_sel),
    .dout     (reg_stat_dout)
  );
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^reg_stat_sel;
  assign reg_stat_dout   = '0;
`endif

endmodule

// File: tb/tb_api_rx_parser.sv
// Randomized self-checking bench for api_rx_parser with a block-level reference model.
module tb_api_rx_parser;

  localparam logic [31:0] MARKER = 32'hbeafbeaf;
  localparam logic [7:0]  TAG    = 8'h12;

  typedef logic [31:0] blk_t [11];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_rst = 1'b0;
  logic        rx_fifo_empty = 1'b1;
  logic        rx_fifo_rd_en;
  logic [31:0] rx_fifo_dout = '0;
  logic        nonce_fifo_wr_en;
  logic [31:0] nonce_fifo_din;
  logic [9:0]  nonce_fifo_data_count = '0;
  logic [31:0] reg_nonce_cnt;
  logic [15:0] reg_drop_cnt;
  logic [15:0] reg_sync_err;
  logic [3:0]  reg_stat_sel = '0;
  logic [15:0] reg_stat_dout;
  logic        busy;

  api_rx_parser dut (
    .clk                   (clk),
    .rst                   (rst),
    .reg_rst               (reg_rst),
    .rx_fifo_empty         (rx_fifo_empty),
    .rx_fifo_rd_en         (rx_fifo_rd_en),
    .rx_fifo_dout          (rx_fifo_dout),
    .nonce_fifo_wr_en      (nonce_fifo_wr_en),
    .nonce_fifo_din        (nonce_fifo_din),
    .nonce_fifo_data_count (nonce_fifo_data_count),
    .reg_nonce_cnt         (reg_nonce_cnt),
    .reg_drop_cnt          (reg_drop_cnt),
    .reg_sync_err          (reg_sync_err),
    .reg_stat_sel          (reg_stat_sel),
    .reg_stat_dout         (reg_stat_dout),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] rx_q [$];
  logic [31:0] src_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] pend_word = '0;
  bit          pend_vld = 1'b0;
  int          n_pop = 0;
  int          n_wr  = 0;
  int          exp_nonce = 0, exp_drop = 0, exp_sync = 0;
  int          exp_stat [10];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: RX FIFO model (data one cycle after pop) and output write checking
  task automatic tick();
    @(negedge clk);
    if (pend_vld) rx_fifo_dout = pend_word;
    pend_vld = 1'b0;
    if (rx_fifo_rd_en) begin
      n_pop++;
      chk("rx_pop_nonempty", 32'(rx_q.size() != 0), 1);
      if (rx_q.size() != 0) begin
        pend_word = rx_q.pop_front();
        pend_vld  = 1'b1;
      end
    end
    rx_fifo_empty = (rx_q.size() == 0);
    if (nonce_fifo_wr_en) begin
      n_wr++;
      chk("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("wr_data", nonce_fifo_din, exp_q.pop_front());
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    rx_q.push_back(w);
    rx_fifo_empty = 1'b0;
  endtask

  // kind: 0 valid, 1 bad marker, 2 bad tag
  task automatic make_block(input int kind, input logic [3:0] miner, output blk_t b);
    logic [7:0] t;
    for (int i = 0; i < 9; i++) b[i] = $urandom;
    b[9] = (kind == 1) ? (MARKER ^ (32'($urandom_range(1, 255)) << 4)) : MARKER;
    t    = (kind == 2) ? (TAG ^ 8'($urandom_range(1, 255))) : TAG;
    b[10] = {16'($urandom), t, 4'($urandom), miner};
  endtask

  // Reference model: classify by the block rules, queue what must be forwarded
  task automatic add_block(input blk_t b, input bit direct);
    if (b[10][15:8] != TAG) exp_sync++;
    else if (b[9] != MARKER) exp_drop++;
    else begin
      for (int i = 0; i < 11; i++) exp_q.push_back(b[i]);
      exp_nonce++;
      if (b[10][3:0] < 4'd10) exp_stat[b[10][3:0]]++;
    end
    for (int i = 0; i < 11; i++) begin
      if (direct) push_word(b[i]);
      else src_q.push_back(b[i]);
    end
  endtask

  task automatic model_clear();
    exp_q.delete(); rx_q.delete(); src_q.delete();
    pend_vld = 1'b0;
    exp_nonce = 0; exp_drop = 0; exp_sync = 0;
    for (int i = 0; i < 10; i++) exp_stat[i] = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input bit rnd_cnt);
    bit done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (src_q.size() != 0 && $urandom_range(0, 3) != 0) push_word(src_q.pop_front());
      if (rnd_cnt)
        nonce_fifo_data_count = ($urandom_range(0, 9) < 8) ? 10'($urandom_range(0, 400))
                                                          : 10'($urandom_range(502, 512));
      tick();
      if (!busy && rx_q.size() == 0 && src_q.size() == 0 && !pend_vld) begin
        done = 1'b1;
        break;
      end
    end
    nonce_fifo_data_count = '0;
    chk(tag, 32'(done), 1);
  endtask

  task automatic check_counters(input string tag);
    logic [15:0] es;
    chk({tag, "_nonce_cnt"}, reg_nonce_cnt, 32'(exp_nonce));
    chk({tag, "_drop_cnt"}, 32'(reg_drop_cnt), 32'(exp_drop));
    chk({tag, "_sync_err"}, 32'(reg_sync_err), 32'(exp_sync));
    chk({tag, "_pending_words"}, 32'(exp_q.size()), 0);
    for (int s = 0; s < 16; s++) begin
      reg_stat_sel = 4'(s);
      tick();
      tick();
`ifdef API_RX_STAT_EN
      es = (s < 10) ? 16'(exp_stat[s]) : 16'd0;
`else
      es = 16'd0;
`endif
      chk($sformatf("%s_stat%0d", tag, s), 32'(reg_stat_dout), 32'(es));
    end
  endtask

  initial begin
    blk_t b;
    int   n;
    bit   seen;
    model_clear();

    // Reset values
    repeat (3) tick();
    chk("rst_rd_en", 32'(rx_fifo_rd_en), 0);
    chk("rst_wr_en", 32'(nonce_fifo_wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_din", nonce_fifo_din, 0);
    chk("rst_nonce_cnt", reg_nonce_cnt, 0);
    chk("rst_drop_cnt", 32'(reg_drop_cnt), 0);
    chk("rst_sync_err", 32'(reg_sync_err), 0);
    chk("rst_stat_dout", 32'(reg_stat_dout), 0);
    rst = 1'b0;
    tick();

    // Valid block into an empty output FIFO, with cycle count
    make_block(0, 4'd3, b);
    b[10] = 32'hA5A5_1203;
    n_wr = 0; n = 0; seen = 1'b0;
    add_block(b, 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (busy) seen = 1'b1;
      else if (seen) break;
    end
    chk("valid_block_cycles", 32'(n), 26);
    chk("valid_writes", 32'(n_wr), 11);
    check_counters("valid");

    // Bad marker
    make_block(1, 4'd5, b);
    b[9] = 32'h0;
    n_wr = 0; n_pop = 0;
    add_block(b, 1'b1);
    wait_idle("badmark_idle", 200, 1'b0);
    chk("badmark_writes", 32'(n_wr), 0);
    chk("badmark_pops", 32'(n_pop), 11);
    check_counters("badmark");

    // Bad tag
    make_block(0, 4'd5, b);
    b[10] = 32'h0000_3405;
    n_wr = 0;
    add_block(b, 1'b1);
    wait_idle("badtag_idle", 200, 1'b0);
    chk("badtag_writes", 32'(n_wr), 0);
    check_counters("badtag");

    // Back-pressure: no space until occupancy drops to 501
    nonce_fifo_data_count = 10'd505;
    make_block(0, 4'd7, b);
    n_wr = 0;
    add_block(b, 1'b1);
    repeat (40) tick();
    chk("bp505_writes", 32'(n_wr), 0);
    chk("bp505_busy", 32'(busy), 1);
    nonce_fifo_data_count = 10'd502;
    repeat (10) tick();
    chk("bp502_writes", 32'(n_wr), 0);
    nonce_fifo_data_count = 10'd501;
    wait_idle("bp_idle", 200, 1'b0);
    chk("bp_writes", 32'(n_wr), 11);
    check_counters("bp");

    // RX underflow after word 5
    make_block(0, 4'd9, b);
    n_wr = 0;
    add_block(b, 1'b0);
    for (int i = 0; i < 5; i++) push_word(src_q.pop_front());
    repeat (26) tick();
    chk("underflow_stalled_writes", 32'(n_wr), 0);
    chk("underflow_stalled_busy", 32'(busy), 1);
    while (src_q.size() != 0) push_word(src_q.pop_front());
    wait_idle("underflow_idle", 200, 1'b0);
    chk("underflow_writes", 32'(n_wr), 11);
    check_counters("underflow");

    // Soft reset during EMIT word 4
    make_block(0, 4'd1, b);
    n_wr = 0; seen = 1'b0;
    add_block(b, 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (nonce_fifo_wr_en && n_wr == 5) begin
        seen = 1'b1;
        break;
      end
    end
    chk("regrst_reached_word4", 32'(seen), 1);
    reg_rst = 1'b1;
    model_clear();
    tick();
    chk("regrst_wr_stopped", 32'(nonce_fifo_wr_en), 0);
    chk("regrst_busy", 32'(busy), 0);
    reg_rst = 1'b0;
    check_counters("regrst");
    make_block(0, 4'd2, b);
    n_wr = 0;
    add_block(b, 1'b1);
    wait_idle("post_regrst_idle", 200, 1'b0);
    chk("post_regrst_writes", 32'(n_wr), 11);
    check_counters("post_regrst");

    // Randomized stream: mixed blocks, RX gaps, random output occupancy
    for (int k = 0; k < 30; k++) begin
      n = $urandom_range(0, 5);
      make_block((n < 4) ? 0 : n - 3, 4'($urandom_range(0, 15)), b);
      add_block(b, 1'b0);
    end
    wait_idle("random_idle", 20000, 1'b1);
    check_counters("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
